idma_desc64_mc_arbiter: RTL
===========================

// Module: idma_desc64_mc_arbiter
// PURPOSE
//  Multi-channel successor stage for the desc64 frontend: merges NumChannels independent descriptor
//  frontends onto one iDMA backend request/response pair. Round-robin arbitrates requests, records
//  the issuing channel of each accepted request in a pending FIFO, and routes in-order backend
//  responses back to the issuing channel. Sits between per-channel desc64 frontends and the backend.
// PARAMETERS
//  NumChannels   4           number of frontend channels (>=1)
//  PendingDepth  8           max backend requests in flight (>=2)
//  idma_req_t    logic       backend request struct (passed through unchanged)
//  idma_rsp_t    logic       backend response struct (passed through unchanged)
//  ChIdxW        derived     NumChannels>1 ? $clog2(NumChannels) : 1
//  CntW          derived     $clog2(PendingDepth+1)
// PORTS
//  clk_i             in   1                   clock
//  rst_i             in   1                   reset, synchronous, active-high
//  ch_req_i          in   NumChannels x req   per-channel request
//  ch_req_valid_i    in   NumChannels         per-channel request valid
//  ch_req_ready_o    out  NumChannels         per-channel request ready
//  ch_rsp_o          out  NumChannels x rsp   per-channel response (all copies of idma_rsp_i)
//  ch_rsp_valid_o    out  NumChannels         per-channel response valid
//  ch_rsp_ready_i    in   NumChannels         per-channel response ready
//  ch_busy_o         out  NumChannels         channel has >=1 request in flight
//  idma_req_o        out  req                 backend request
//  idma_req_valid_o  out  1                   backend request valid
//  idma_req_ready_i  in   1                   backend request ready
//  idma_rsp_i        in   rsp                 backend response
//  idma_rsp_valid_i  in   1                   backend response valid
//  idma_rsp_ready_o  out  1                   backend response ready
//  pending_cnt_o     out  CntW                total requests in flight
//  spurious_rsp_o    out  1                   sticky: response arrived with no request pending
// BEHAVIOUR
//  - Single clock clk_i; rst_i synchronous active-high. Reset (incl. mid-transfer): FIFO emptied,
//    counters 0, lock cleared, rr pointer = NumChannels-1 (channel 0 wins first), spurious_rsp_o=0;
//    all valid/ready/busy outputs 0 in the cycle after reset. In-flight bookkeeping is discarded.
//  - Arbitration: when unlocked, grant lowest index at or after (ptr+1) mod N with valid set.
//    idma_req_valid_o = any granted valid & !fifo_full; idma_req_o = ch_req_i[grant] (combinational,
//    zero latency). Once valid shown without handshake, grant locks until handshake (no retraction,
//    no switch even if a higher-priority channel raises valid). ptr updates only on handshake.
//  - ch_req_ready_o[g] = idma_req_ready_i & !fifo_full for granted g only; others 0.
//  - Pending FIFO full: valid=0, all ready=0; a pop in the same cycle does NOT enable a push.
//  - Backend request handshake: push grant index; inc cnt[g]. Response handshake: pop head; dec cnt[head].
//  - Response routing: ch_rsp_valid_o[head] = idma_rsp_valid_i & !empty; others 0.
//    idma_rsp_ready_o = ch_rsp_ready_i[head] & !empty. Responses strictly in request order.
//  - Empty FIFO + idma_rsp_valid_i: idma_rsp_ready_o=0, nothing routed, spurious_rsp_o set (sticky).
//  - Simultaneous push and pop: both occur; same-channel inc+dec leaves cnt unchanged.
//  - ch_busy_o[i] = cnt[i]!=0 (registered count); pending_cnt_o = FIFO fill level.
//  - Counters/pointers wrap modulo depth; cnt cannot exceed PendingDepth by construction.
//  - NumChannels==1: arbiter degenerates to pass-through gated only by fifo_full.
// STRUCTURE
//  - Package idma_desc64_mc_pkg: ChIdxW/CntW helper functions; no struct typedefs (types are params).
//  - Sub-module idma_desc64_mc_rr_arb: lock-on-valid round-robin arbiter (req vec, handshake in,
//    grant idx/onehot out). Pending FIFO and counters inline in this module.
// TESTING
//  - Reset, ch0..3 all valid, ready=1: grants 0,1,2,3,0 on consecutive cycles; busy=4'b1111.
//  - Grant ch2 with ready=0 for 5 cycles, raise ch0 valid: ch2 held, req stable, ch2 issued first.
//  - 8 requests issued, no responses: 9th blocked, all ready=0, pending_cnt_o=8; one pop -> push next cycle.
//  - Issue ch1,ch3,ch1; three responses: routed to 1,3,1; ch_busy_o[1] clears only after third.
//  - Response with FIFO empty: idma_rsp_ready_o=0, spurious_rsp_o=1 and stays 1 until rst_i.
//  - rst_i asserted with 5 in flight and locked grant: next cycle all outputs 0, first grant = ch0.

Source files
------------

// File: rtl/idma_desc64_mc_pkg.sv
// Shared helpers for the multi-channel desc64 arbiter.
//   ch_idx_w(n)  : width of a channel index (at least 1 bit, even for a single channel)
//   cnt_w(d)     : width of a counter that must hold values 0..d inclusive
//   arb_state_e  : lock state of the round-robin arbiter
package idma_desc64_mc_pkg;

  function automatic int unsigned ch_idx_w(input int unsigned num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic {
    ArbOpen   = 1'b0,  // free to pick a new winner every cycle
    ArbLocked = 1'b1   // a request was shown downstream and awaits its handshake
  } arb_state_e;

endpackage

// File: rtl/idma_desc64_mc_rr_arb.sv
// Lock-on-valid round-robin arbiter.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i         : per-channel request valid
//   shown_i       : the granted request is visible downstream this cycle
//   hs_i          : the granted request completes its handshake this cycle
//   gnt_idx_o     : granted channel index
//   gnt_onehot_o  : granted channel, one-hot, zero when the granted channel has no request
//   gnt_valid_o   : the granted channel has a request
// The search starts one past the last channel that completed a handshake. Once a request
// has been shown without a handshake the grant is frozen until that handshake happens.
module idma_desc64_mc_rr_arb
  import idma_desc64_mc_pkg::*;
#(
  parameter  int unsigned NumChannels = 4,
  localparam int unsigned ChIdxW      = ch_idx_w(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   shown_i,
  input  logic                   hs_i,
  output logic [ChIdxW-1:0]      gnt_idx_o,
  output logic [NumChannels-1:0] gnt_onehot_o,
  output logic                   gnt_valid_o
);

  arb_state_e        state_q, state_d;
  logic [ChIdxW-1:0] ptr_q, lock_idx_q;
  logic [ChIdxW-1:0] search_idx, cand;
  logic              search_hit;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ArbOpen;
      ptr_q      <= ChIdxW'(NumChannels - 1);  // channel 0 wins first
      lock_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs_i)    ptr_q      <= gnt_idx_o;
      // While locked gnt_idx_o already equals lock_idx_q, so this only captures a fresh winner.
      if (shown_i) lock_idx_q <= gnt_idx_o;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbOpen:   if (shown_i && !hs_i) state_d = ArbLocked;
      ArbLocked: if (hs_i)             state_d = ArbOpen;
      default:                         state_d = ArbOpen;
    endcase
  end

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    search_hit = 1'b0;
    search_idx = ptr_q;
    cand       = '0;
    for (int unsigned i = 1; i <= NumChannels; i++) begin
      cand = ChIdxW'((32'(ptr_q) + i) % NumChannels);
      if (!search_hit && req_i[cand]) begin
        search_hit = 1'b1;
        search_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_idx_o               = (state_q == ArbLocked) ? lock_idx_q : search_idx;
    gnt_valid_o             = req_i[gnt_idx_o];
    gnt_onehot_o            = '0;
    gnt_onehot_o[gnt_idx_o] = gnt_valid_o;
  end

endmodule

// File: rtl/idma_desc64_mc_arbiter.sv
// Merges NumChannels desc64 frontends onto one iDMA backend request/response pair.
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   ch_req_i / _valid_i / _ready_o   : per-channel request channels
//   ch_rsp_o / _valid_o / _ready_i   : per-channel response channels (data is a copy of idma_rsp_i)
//   ch_busy_o                        : channel has at least one request in flight
//   idma_req_o / _valid_o / _ready_i : backend request
//   idma_rsp_i / _valid_i / _ready_o : backend response (in request order)
//   pending_cnt_o                    : total requests in flight
//   spurious_rsp_o                   : sticky, a response arrived while nothing was pending
// Each accepted request pushes its channel index into a pending FIFO; the FIFO head steers the
// next backend response back to its issuer. All handshakes are suppressed while rst_i is high.
module idma_desc64_mc_arbiter
  import idma_desc64_mc_pkg::*;
#(
  parameter  int unsigned NumChannels  = 4,
  parameter  int unsigned PendingDepth = 8,
  parameter  type         idma_req_t   = logic,
  parameter  type         idma_rsp_t   = logic,
  localparam int unsigned ChIdxW       = ch_idx_w(NumChannels),
  localparam int unsigned CntW         = cnt_w(PendingDepth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  idma_req_t              ch_req_i       [NumChannels],
  input  logic [NumChannels-1:0] ch_req_valid_i,
  output logic [NumChannels-1:0] ch_req_ready_o,
  output idma_rsp_t              ch_rsp_o       [NumChannels],
  output logic [NumChannels-1:0] ch_rsp_valid_o,
  input  logic [NumChannels-1:0] ch_rsp_ready_i,
  output logic [NumChannels-1:0] ch_busy_o,
  output idma_req_t              idma_req_o,
  output logic                   idma_req_valid_o,
  input  logic                   idma_req_ready_i,
  input  idma_rsp_t              idma_rsp_i,
  input  logic                   idma_rsp_valid_i,
  output logic                   idma_rsp_ready_o,
  output logic [CntW-1:0]        pending_cnt_o,
  output logic                   spurious_rsp_o
);

  localparam int unsigned PtrW = $clog2(PendingDepth);

  logic [ChIdxW-1:0]      fifo_q [PendingDepth];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        fill_q;
  logic [CntW-1:0]        cnt_q  [NumChannels];
  logic                   spurious_q;
  logic                   fifo_full, fifo_empty, req_shown, push, pop;
  logic [ChIdxW-1:0]      gnt_idx, head_idx;
  logic [NumChannels-1:0] gnt_onehot;
  logic                   gnt_valid;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(PendingDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_full  = (fill_q == CntW'(PendingDepth));
  assign fifo_empty = (fill_q == '0);
  assign head_idx   = fifo_q[rd_ptr_q];

  // A pop in the same cycle deliberately does not free a slot for a push.
  assign req_shown  = gnt_valid && !fifo_full && !rst_i;
  assign push       = req_shown && idma_req_ready_i;
  assign pop        = idma_rsp_valid_i && idma_rsp_ready_o;

  idma_desc64_mc_rr_arb #(
    .NumChannels (NumChannels)
  ) i_rr_arb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (ch_req_valid_i),
    .shown_i      (req_shown),
    .hs_i         (push),
    .gnt_idx_o    (gnt_idx),
    .gnt_onehot_o (gnt_onehot),
    .gnt_valid_o  (gnt_valid)
  );

  always_comb begin
    idma_req_valid_o         = req_shown;
    idma_req_o               = ch_req_i[gnt_idx];
    ch_req_ready_o           = (idma_req_ready_i && !fifo_full && !rst_i) ? gnt_onehot : '0;
    idma_rsp_ready_o         = !fifo_empty && !rst_i && ch_rsp_ready_i[head_idx];
    ch_rsp_valid_o           = '0;
    ch_rsp_valid_o[head_idx] = idma_rsp_valid_i && !fifo_empty && !rst_i;
    for (int i = 0; i < NumChannels; i++) begin
      ch_rsp_o[i]  = idma_rsp_i;
      ch_busy_o[i] = (cnt_q[i] != '0);
    end
    pending_cnt_o  = fill_q;
    spurious_rsp_o = spurious_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      spurious_q <= 1'b0;
      for (int i = 0; i < NumChannels; i++) cnt_q[i] <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + CntW'(1);
        2'b01:   fill_q <= fill_q - CntW'(1);
        default: fill_q <= fill_q;
      endcase
      // Same-channel push and pop cancel out.
      for (int i = 0; i < NumChannels; i++) begin
        cnt_q[i] <= cnt_q[i]
                  + CntW'(push && (gnt_idx  == ChIdxW'(i)))
                  - CntW'(pop  && (head_idx == ChIdxW'(i)));
      end
      if (idma_rsp_valid_i && fifo_empty) spurious_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after the push that wrote it.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_idx;
  end

endmodule
